// File: rtl/apb2axi_rd_drain_pkg.sv
// ----------------------------------------------------------------------------
// apb2axi_rd_drain_pkg
// Shared types and constants for the APB-side read/completion drain block.
//   - APB bus widths, completion queue entry and read-data FIFO entry layouts
//   - register window offsets (relative to the block base)
//   - drain FSM state encoding
//   - COMPL_STATUS / DRAIN_STAT field positions and word builders
// ----------------------------------------------------------------------------
package apb2axi_rd_drain_pkg;

  localparam int APB_ADDR_W = 16;
  localparam int APB_DATA_W = 32;
  localparam int TAG_W      = 4;
  localparam int RD_DATA_W  = 64;

  // Completion queue entry, written by the AXI B/R-channel logic.
  typedef struct packed {
    logic             is_write;
    logic             error;
    logic [1:0]       resp;
    logic [TAG_W-1:0] tag;
    logic [7:0]       num_beats;
  } completion_entry_t;

  // Read data FIFO entry, one per AXI R beat.
  typedef struct packed {
    logic [TAG_W-1:0]     tag;
    logic [RD_DATA_W-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } rdf_entry_t;

  localparam int COMPLETION_W = $bits(completion_entry_t);
  localparam int RDF_W        = $bits(rdf_entry_t);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } rd_drain_state_e;

  // Register offsets within the window.
  localparam logic [APB_ADDR_W-1:0] OFS_COMPL_STATUS = 16'h0000;
  localparam logic [APB_ADDR_W-1:0] OFS_COMPL_POP    = 16'h0004;
  localparam logic [APB_ADDR_W-1:0] OFS_RDATA_LO     = 16'h0008;
  localparam logic [APB_ADDR_W-1:0] OFS_RDATA_HI     = 16'h000C;
  localparam logic [APB_ADDR_W-1:0] OFS_DRAIN_STAT   = 16'h0010;

  // COMPL_STATUS field positions.
  localparam int CS_VALID_BIT    = 31;
  localparam int CS_IS_WRITE_BIT = 30;
  localparam int CS_ERROR_BIT    = 29;
  localparam int CS_RESP_LSB     = 27;
  localparam int CS_TAG_LSB      = 16;
  localparam int CS_BEATS_LSB    = 0;

  // DRAIN_STAT field positions.
  localparam int DS_STICKY_BIT   = 31;
  localparam int DS_RESP_LSB     = 16;
  localparam int DS_BEATS_LSB    = 0;

  function automatic logic [APB_DATA_W-1:0] compl_status_word(
    input logic              valid,
    input completion_entry_t e
  );
    logic [APB_DATA_W-1:0] w;
    w = '0;
    w[CS_VALID_BIT]            = valid;
    w[CS_IS_WRITE_BIT]         = e.is_write;
    w[CS_ERROR_BIT]            = e.error;
    w[CS_RESP_LSB +: 2]        = e.resp;
    w[CS_TAG_LSB +: TAG_W]     = e.tag;
    w[CS_BEATS_LSB +: 8]       = e.num_beats;
    return w;
  endfunction

  function automatic logic [APB_DATA_W-1:0] drain_stat_word(
    input logic       sticky_err,
    input logic [1:0] last_resp,
    input logic [7:0] beats_left
  );
    logic [APB_DATA_W-1:0] w;
    w = '0;
    w[DS_STICKY_BIT]    = sticky_err;
    w[DS_RESP_LSB +: 2] = last_resp;
    w[DS_BEATS_LSB +: 8] = beats_left;
    return w;
  endfunction

endpackage

// File: rtl/apb2axi_rd_drain_if.sv
// ----------------------------------------------------------------------------
// apb2axi_rd_drain_if
// Bus bundle for the drain block: the APB slave signals plus the pop-side
// handshakes of the completion queue (cq_*) and read data FIFO (rdf_*).
//   slave  : view of the drain block (APB responder, FIFO reader)
//   master : view of the surrounding logic / APB host / FIFOs
// ----------------------------------------------------------------------------
interface apb2axi_rd_drain_if;
  import apb2axi_rd_drain_pkg::*;

  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [APB_ADDR_W-1:0]   paddr;
  logic [APB_DATA_W-1:0]   pwdata;
  logic [APB_DATA_W-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  logic                    cq_valid;
  logic [COMPLETION_W-1:0] cq_entry;
  logic                    cq_pop;

  logic                    rdf_valid;
  logic [RDF_W-1:0]        rdf_entry;
  logic                    rdf_pop;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    input  cq_valid, cq_entry, rdf_valid, rdf_entry,
    output prdata, pready, pslverr, cq_pop, rdf_pop
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    output cq_valid, cq_entry, rdf_valid, rdf_entry,
    input  prdata, pready, pslverr, cq_pop, rdf_pop
  );

endinterface

// File: rtl/apb2axi_apb_slv_if.sv
// ----------------------------------------------------------------------------
// apb2axi_apb_slv_if
// APB access decoder for the drain block register window.
//   clk, rst           : clock, asynchronous active-high reset
//   psel_i .. paddr_i  : APB request signals
//   stall_i            : the current access wants to wait (empty RDF)
//   access_o           : access phase in progress (psel & penable)
//   pready_o           : access completes this cycle
//   timeout_o          : stall limit reached, access completes with error
//   rd_*_o / wr_pop_o  : per-register strobes, valid for the whole access
//   bad_o              : unmapped offset or wrong direction
// ----------------------------------------------------------------------------
module apb2axi_apb_slv_if
  import apb2axi_rd_drain_pkg::*;
#(
  parameter int                    RDF_TIMEOUT = 64,
  parameter logic [APB_ADDR_W-1:0] BASE_OFS    = 16'h10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [APB_ADDR_W-1:0] paddr_i,
  input  logic                  stall_i,
  output logic                  access_o,
  output logic                  pready_o,
  output logic                  timeout_o,
  output logic                  rd_status_o,
  output logic                  wr_pop_o,
  output logic                  rd_lo_o,
  output logic                  rd_hi_o,
  output logic                  rd_dstat_o,
  output logic                  bad_o
);

  // Wide enough to hold RDF_TIMEOUT-1 for any RDF_TIMEOUT >= 1.
  localparam int WAIT_W = $clog2(RDF_TIMEOUT + 1);

  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [APB_ADDR_W-1:0] ofs;

  // Addresses below the base wrap to large offsets and decode as unmapped.
  assign ofs      = paddr_i - BASE_OFS;
  assign access_o = psel_i & penable_i;

  assign rd_status_o = access_o & ~pwrite_i & (ofs == OFS_COMPL_STATUS);
  assign wr_pop_o    = access_o &  pwrite_i & (ofs == OFS_COMPL_POP);
  assign rd_lo_o     = access_o & ~pwrite_i & (ofs == OFS_RDATA_LO);
  assign rd_hi_o     = access_o & ~pwrite_i & (ofs == OFS_RDATA_HI);
  assign rd_dstat_o  = access_o & ~pwrite_i & (ofs == OFS_DRAIN_STAT);
  assign bad_o       = access_o & ~(rd_status_o | wr_pop_o | rd_lo_o |
                                    rd_hi_o | rd_dstat_o);

  // wait_q counts access cycles already spent stalled, so the limit is hit
  // on the RDF_TIMEOUT-th access cycle of the same transfer.
  assign timeout_o = access_o & stall_i &
                     (wait_q == WAIT_W'(RDF_TIMEOUT - 1));
  assign pready_o  = access_o & (~stall_i | timeout_o);

  always_comb begin
    wait_d = '0;
    if (access_o && stall_i && !timeout_o) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

endmodule

// File: rtl/apb2axi_rd_drain.sv
// ----------------------------------------------------------------------------
// apb2axi_rd_drain
// APB-side reader for the converter return path. Pops one completion at a
// time into a holding register, and for read completions lets the host pull
// the read beats out of the RDF through RDATA_LO/RDATA_HI.
//   clk  : clock
//   rst  : asynchronous active-high reset; all outputs forced to 0 while high
//   bus  : APB slave + completion queue / RDF pop interface (slave modport)
// Registers (offset from BASE_OFS):
//   0x00 COMPL_STATUS RO, 0x04 COMPL_POP WO, 0x08 RDATA_LO RO,
//   0x0C RDATA_HI RO (pops RDF), 0x10 DRAIN_STAT RO
// ----------------------------------------------------------------------------
module apb2axi_rd_drain
  import apb2axi_rd_drain_pkg::*;
#(
  parameter int                    RDF_TIMEOUT = 64,
  parameter logic [APB_ADDR_W-1:0] BASE_OFS    = 16'h10
) (
  input  logic             clk,
  input  logic             rst,
  apb2axi_rd_drain_if.slave bus
);

  rd_drain_state_e   state_q, state_d;
  completion_entry_t hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
  logic [7:0]        beats_left_q, beats_left_d;
  logic              sticky_err_q, sticky_err_d;
  logic [1:0]        last_resp_q, last_resp_d;

  completion_entry_t cq_e;
  rdf_entry_t        rdf_e;

  logic access, pready, timeout, stall;
  logic rd_status, wr_pop, rd_lo, rd_hi, rd_dstat, bad;

  logic [APB_DATA_W-1:0] prdata_c;
  logic                  pslverr_c;
  logic                  cq_pop_c;
  logic                  rdf_pop_c;
  logic                  beat_err;

  // The write data carries no information; the write itself is the strobe.
  logic unused_pwdata;
  assign unused_pwdata = ^bus.pwdata;

  assign cq_e  = completion_entry_t'(bus.cq_entry);
  assign rdf_e = rdf_entry_t'(bus.rdf_entry);

  // RDATA accesses in DRAIN wait for the RDF; outside DRAIN they fail at once.
  assign stall = (rd_lo | rd_hi) & (state_q == DRAIN) & ~bus.rdf_valid;

  apb2axi_apb_slv_if #(
    .RDF_TIMEOUT (RDF_TIMEOUT),
    .BASE_OFS    (BASE_OFS)
  ) u_apb_slv (
    .clk         (clk),
    .rst         (rst),
    .psel_i      (bus.psel),
    .penable_i   (bus.penable),
    .pwrite_i    (bus.pwrite),
    .paddr_i     (bus.paddr),
    .stall_i     (stall),
    .access_o    (access),
    .pready_o    (pready),
    .timeout_o   (timeout),
    .rd_status_o (rd_status),
    .wr_pop_o    (wr_pop),
    .rd_lo_o     (rd_lo),
    .rd_hi_o     (rd_hi),
    .rd_dstat_o  (rd_dstat),
    .bad_o       (bad)
  );

  // A popped beat is flagged when it belongs to another transaction or its
  // last bit disagrees with the remaining beat count.
  assign beat_err = (rdf_e.tag != hold_q.tag) ||
                    (rdf_e.last != (beats_left_q == 8'd1));

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    beats_left_d = beats_left_q;
    sticky_err_d = sticky_err_q;
    last_resp_d  = last_resp_q;
    prdata_c     = '0;
    pslverr_c    = 1'b0;
    cq_pop_c     = 1'b0;
    rdf_pop_c    = 1'b0;

    if (access) begin
      // APB access owns this cycle; any pending completion latch waits.
      if (bad) begin
        pslverr_c = 1'b1;
      end else if (rd_status) begin
        prdata_c = compl_status_word(hold_valid_q, hold_q);
      end else if (rd_dstat) begin
        prdata_c = drain_stat_word(sticky_err_q, last_resp_q, beats_left_q);
      end else if (wr_pop) begin
        if (state_q == HOLD) begin
          hold_valid_d = 1'b0;
          hold_d       = '0;
          state_d      = IDLE;
        end else begin
          pslverr_c = 1'b1;
        end
      end else if (state_q != DRAIN) begin
        // RDATA_LO / RDATA_HI with nothing to drain.
        pslverr_c = 1'b1;
      end else if (!bus.rdf_valid) begin
        // Stalled: pready is low until either data arrives or the limit.
        pslverr_c = timeout;
      end else if (rd_lo) begin
        prdata_c = rdf_e.data[31:0];
      end else begin
        prdata_c     = rdf_e.data[63:32];
        rdf_pop_c    = 1'b1;
        last_resp_d  = rdf_e.resp;
        beats_left_d = beats_left_q - 8'd1;
        if (beat_err) begin
          pslverr_c    = 1'b1;
          sticky_err_d = 1'b1;
        end
        if (beats_left_q == 8'd1) begin
          state_d = HOLD;
        end
      end
    end else if (state_q == IDLE && bus.cq_valid) begin
      cq_pop_c     = 1'b1;
      hold_d       = cq_e;
      hold_valid_d = 1'b1;
      if (cq_e.is_write || cq_e.num_beats == 8'd0) begin
        beats_left_d = 8'd0;
        state_d      = HOLD;
      end else begin
        beats_left_d = cq_e.num_beats;
        sticky_err_d = 1'b0;
        state_d      = DRAIN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      beats_left_q <= '0;
      sticky_err_q <= 1'b0;
      last_resp_q  <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      beats_left_q <= beats_left_d;
      sticky_err_q <= sticky_err_d;
      last_resp_q  <= last_resp_d;
    end
  end

  // Outputs are combinational, so they are masked directly by reset to stay
  // at 0 the moment reset rises, even mid-access.
  assign bus.pready  = pready    & ~rst;
  assign bus.pslverr = pslverr_c & pready & ~rst;
  assign bus.prdata  = (pready & ~rst) ? prdata_c : '0;
  assign bus.cq_pop  = cq_pop_c  & ~rst;
  assign bus.rdf_pop = rdf_pop_c & ~rst;

endmodule

// File: tb/tb_apb2axi_rd_drain.sv
// ----------------------------------------------------------------------------
// tb_apb2axi_rd_drain
// Directed scoreboard bench: each APB transfer pushes its expected
// prdata/pslverr into a queue, and a monitor pops and compares whenever the
// DUT completes an access. Queue models feed the completion queue and RDF.
// ----------------------------------------------------------------------------
module tb_apb2axi_rd_drain;
  import apb2axi_rd_drain_pkg::*;

  localparam logic [15:0] A_STATUS = 16'h0010;
  localparam logic [15:0] A_POP    = 16'h0014;
  localparam logic [15:0] A_LO     = 16'h0018;
  localparam logic [15:0] A_HI     = 16'h001C;
  localparam logic [15:0] A_DSTAT  = 16'h0020;
  localparam logic [15:0] A_BAD    = 16'h0024;

  typedef struct {
    logic [31:0] data;
    logic        err;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb2axi_rd_drain_if bus();

  apb2axi_rd_drain #(
    .RDF_TIMEOUT (64),
    .BASE_OFS    (16'h10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  exp_t              exp_q[$];
  completion_entry_t cq_q[$];
  rdf_entry_t        rdf_q[$];
  logic              rdf_en = 1'b1;
  int                cq_pops = 0;
  int                rdf_pops = 0;

  function automatic completion_entry_t mk_cq(input logic w, input logic [3:0] tag,
                                              input logic [7:0] nb);
    completion_entry_t e;
    e.is_write  = w;
    e.error     = 1'b0;
    e.resp      = 2'b00;
    e.tag       = tag;
    e.num_beats = nb;
    return e;
  endfunction

  function automatic rdf_entry_t mk_rdf(input logic [3:0] tag, input logic [63:0] d,
                                        input logic [1:0] resp, input logic last);
    rdf_entry_t e;
    e.tag  = tag;
    e.data = d;
    e.resp = resp;
    e.last = last;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, got, want);
    end else begin
      $display("pass %s: 0x%08h", nm, got);
    end
  endtask

  // FIFO models: pops are sampled mid-cycle and applied after the edge.
  initial begin : fifo_model
    logic cq_pend, rdf_pend;
    bus.cq_valid  = 1'b0;
    bus.cq_entry  = '0;
    bus.rdf_valid = 1'b0;
    bus.rdf_entry = '0;
    forever begin
      @(negedge clk);
      cq_pend  = bus.cq_pop;
      rdf_pend = bus.rdf_pop;
      if (cq_pend)  cq_pops++;
      if (rdf_pend) rdf_pops++;
      @(posedge clk);
      #1;
      if (cq_pend && cq_q.size() > 0)   cq_q.delete(0);
      if (rdf_pend && rdf_q.size() > 0) rdf_q.delete(0);
      #1;
      bus.cq_valid = (cq_q.size() > 0);
      if (cq_q.size() > 0) bus.cq_entry = cq_q[0];
      else                 bus.cq_entry = '0;
      bus.rdf_valid = rdf_en && (rdf_q.size() > 0);
      if (rdf_q.size() > 0) bus.rdf_entry = rdf_q[0];
      else                  bus.rdf_entry = '0;
    end
  end

  // Scoreboard monitor: one comparison per completed APB access.
  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst && bus.psel && bus.penable && bus.pready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_access: got prdata 0x%08h err %0b want no access",
                   bus.prdata, bus.pslverr);
        end else begin
          x = exp_q.pop_front();
          if (bus.prdata !== x.data || bus.pslverr !== x.err) begin
            errors++;
            $display("FAIL %s: got prdata 0x%08h err %0b want 0x%08h err %0b",
                     x.name, bus.prdata, bus.pslverr, x.data, x.err);
          end else begin
            $display("pass %s: prdata 0x%08h err %0b", x.name, bus.prdata, bus.pslverr);
          end
        end
      end
    end
  end

  // One APB transfer; raise_at>0 re-enables the RDF after that many stall cycles.
  task automatic apb(input logic w, input logic [15:0] a, input logic [31:0] d,
                     input logic e, input string nm, input int raise_at, output int waits);
    exp_t x;
    x.data = d;
    x.err  = e;
    x.name = nm;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = w;
    bus.paddr   = a;
    bus.pwdata  = w ? 32'h1 : 32'h0;
    @(posedge clk);
    #1;
    bus.penable = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (bus.pready) break;
      waits++;
      if (waits == raise_at) begin
        @(posedge clk);
        #1;
        rdf_en = 1'b1;
      end
      if (waits > 200) begin
        errors++;
        checks++;
        $display("FAIL %s_pready: got no pready after %0d cycles want completion", nm, waits);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] d, input logic e,
                    input string nm);
    int w;
    apb(1'b0, a, d, e, nm, -1, w);
  endtask

  task automatic wr(input logic [15:0] a, input logic e, input string nm);
    int w;
    apb(1'b1, a, 32'h0, e, nm, -1, w);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = '0;
    bus.pwdata  = '0;

    // ---- reset: outputs held at 0 with a pending completion and an access
    cq_q.push_back(mk_cq(1'b1, 4'd3, 8'd0));
    idle(3);
    bus.psel    = 1'b1;
    bus.penable = 1'b1;
    bus.paddr   = A_STATUS;
    @(negedge clk);
    chk("rst_pready",  {31'b0, bus.pready},  32'h0);
    chk("rst_pslverr", {31'b0, bus.pslverr}, 32'h0);
    chk("rst_prdata",  bus.prdata,           32'h0);
    chk("rst_cq_pop",  {31'b0, bus.cq_pop},  32'h0);
    chk("rst_rdf_pop", {31'b0, bus.rdf_pop}, 32'h0);
    @(posedge clk);
    #1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    rst         = 1'b0;
    idle(3);

    // ---- write completion, tag 3
    chk("wr_cq_pops", cq_pops, 32'd1);
    rd(A_STATUS, 32'hC003_0000, 1'b0, "wr_status");
    rd(A_DSTAT,  32'h0000_0000, 1'b0, "wr_dstat");
    wr(A_POP, 1'b0, "wr_compl_pop");
    rd(A_STATUS, 32'h0000_0000, 1'b0, "wr_status_after_pop");
    wr(A_POP, 1'b1, "pop_in_idle");
    rd(A_LO, 32'h0000_0000, 1'b1, "rdlo_in_idle");
    chk("wr_cq_pops_final", cq_pops, 32'd1);

    // ---- 4-beat read, tag 5
    cq_q.push_back(mk_cq(1'b0, 4'd5, 8'd4));
    rdf_q.push_back(mk_rdf(4'd5, 64'h1111_2222_3333_4444, 2'b00, 1'b0));
    rdf_q.push_back(mk_rdf(4'd5, 64'h5555_6666_7777_8888, 2'b00, 1'b0));
    rdf_q.push_back(mk_rdf(4'd5, 64'h9999_AAAA_BBBB_CCCC, 2'b00, 1'b0));
    rdf_q.push_back(mk_rdf(4'd5, 64'hDDDD_EEEE_FFFF_0000, 2'b01, 1'b1));
    idle(4);
    chk("rd4_cq_pops", cq_pops, 32'd2);
    rd(A_STATUS, 32'h8005_0004, 1'b0, "rd4_status");
    rd(A_DSTAT,  32'h0000_0004, 1'b0, "rd4_dstat_4");
    rd(A_LO, 32'h3333_4444, 1'b0, "rd4_b1_lo");
    rd(A_HI, 32'h1111_2222, 1'b0, "rd4_b1_hi");
    rd(A_LO, 32'h7777_8888, 1'b0, "rd4_b2_lo");
    rd(A_HI, 32'h5555_6666, 1'b0, "rd4_b2_hi");
    rd(A_DSTAT, 32'h0000_0002, 1'b0, "rd4_dstat_2");
    wr(A_POP, 1'b1, "pop_in_drain");
    rd(A_DSTAT, 32'h0000_0002, 1'b0, "rd4_dstat_2_kept");
    rd(A_LO, 32'hBBBB_CCCC, 1'b0, "rd4_b3_lo");
    rd(A_HI, 32'h9999_AAAA, 1'b0, "rd4_b3_hi");
    rd(A_LO, 32'hFFFF_0000, 1'b0, "rd4_b4_lo");
    rd(A_HI, 32'hDDDD_EEEE, 1'b0, "rd4_b4_hi");
    rd(A_DSTAT, 32'h0001_0000, 1'b0, "rd4_dstat_0");
    chk("rd4_rdf_pops", rdf_pops, 32'd4);
    rd(A_STATUS, 32'h8005_0004, 1'b0, "rd4_status_hold");
    wr(A_POP, 1'b0, "rd4_compl_pop");

    // ---- empty-RDF stall and timeout, tag 7
    rdf_en = 1'b0;
    cq_q.push_back(mk_cq(1'b0, 4'd7, 8'd2));
    rdf_q.push_back(mk_rdf(4'd7, 64'h0123_4567_89AB_CDEF, 2'b00, 1'b0));
    rdf_q.push_back(mk_rdf(4'd7, 64'hFEDC_BA98_7654_3210, 2'b00, 1'b1));
    idle(4);
    apb(1'b0, A_HI, 32'h0123_4567, 1'b0, "stall_hi", 10, w);
    chk("stall_wait_cycles", w, 32'd10);
    chk("stall_rdf_pops", rdf_pops, 32'd5);
    rdf_en = 1'b0;
    idle(1);
    apb(1'b0, A_HI, 32'h0000_0000, 1'b1, "timeout_hi", -1, w);
    chk("timeout_wait_cycles", w, 32'd63);
    chk("timeout_rdf_pops", rdf_pops, 32'd5);
    rdf_en = 1'b1;
    idle(1);
    rd(A_DSTAT, 32'h0000_0001, 1'b0, "stall_dstat_1");
    rd(A_LO, 32'h7654_3210, 1'b0, "stall_b2_lo");
    rd(A_HI, 32'hFEDC_BA98, 1'b0, "stall_b2_hi");
    rd(A_DSTAT, 32'h0000_0000, 1'b0, "stall_dstat_0");
    chk("stall_rdf_pops_final", rdf_pops, 32'd6);
    wr(A_POP, 1'b0, "stall_compl_pop");

    // ---- tag mismatch: held tag 5, beat tag 6
    cq_q.push_back(mk_cq(1'b0, 4'd5, 8'd1));
    rdf_q.push_back(mk_rdf(4'd6, 64'hAAAA_0000_BBBB_1111, 2'b00, 1'b1));
    idle(4);
    rd(A_HI, 32'hAAAA_0000, 1'b1, "tagerr_hi");
    rd(A_DSTAT, 32'h8000_0000, 1'b0, "tagerr_dstat_sticky");
    chk("tagerr_rdf_pops", rdf_pops, 32'd7);
    rd(A_LO, 32'h0000_0000, 1'b1, "rdlo_in_hold");
    rd(A_BAD, 32'h0000_0000, 1'b1, "bad_offset_0x14");
    wr(A_POP, 1'b0, "tagerr_compl_pop");

    // ---- reset during DRAIN with beats_left=3
    cq_q.push_back(mk_cq(1'b0, 4'd2, 8'd3));
    rdf_q.push_back(mk_rdf(4'd2, 64'h1234_5678_9ABC_DEF0, 2'b00, 1'b0));
    idle(4);
    rd(A_DSTAT, 32'h0000_0003, 1'b0, "rst_drain_dstat_3");
    @(posedge clk);
    #1;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = A_HI;
    @(posedge clk);
    #1;
    bus.penable = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_pready",  {31'b0, bus.pready},  32'h0);
    chk("midrst_prdata",  bus.prdata,           32'h0);
    chk("midrst_pslverr", {31'b0, bus.pslverr}, 32'h0);
    chk("midrst_rdf_pop", {31'b0, bus.rdf_pop}, 32'h0);
    @(posedge clk);
    #1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    rdf_q.delete();
    idle(2);
    rst = 1'b0;
    idle(2);
    rd(A_STATUS, 32'h0000_0000, 1'b0, "postrst_status");
    rd(A_DSTAT,  32'h0000_0000, 1'b0, "postrst_dstat");
    chk("postrst_rdf_pops", rdf_pops, 32'd7);

    idle(2);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
